// File: rtl/led_display_ctrl.sv
// rtl/led_display_ctrl.sv - registered LED driver with static, score, blink, chase and win-flash modes
// Optional feature: define LED_DIM_EN to add the brightness port and a 16-step PWM dimmer.
module led_display_ctrl #(
    parameter int LED_W       = 8,
    parameter int TICK_DIV    = 25000000,
    parameter int BLINK_TICKS = 1,
    parameter int FLASH_CNT   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_load,
    input  logic [2:0]       mode,
    input  logic [LED_W-1:0] pattern,
    input  logic [LED_W-1:0] score,
`ifdef LED_DIM_EN
    input  logic [3:0]       brightness,
`endif
    output logic [LED_W-1:0] leds_out,
    output logic             flash_done
);

    localparam int PRE_W   = $clog2(TICK_DIV);
    localparam int CHASE_W = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int SUB_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int FL_W    = $clog2(FLASH_CNT + 1);

    localparam logic [PRE_W-1:0]   PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [CHASE_W-1:0] CHASE_MAX = CHASE_W'(LED_W - 1);
    localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(BLINK_TICKS - 1);
    localparam logic [FL_W-1:0]    FL_MAX    = FL_W'(FLASH_CNT);

    typedef enum logic [2:0] {
        MODE_OFF     = 3'd0,
        MODE_ON      = 3'd1,
        MODE_SCORE   = 3'd2,
        MODE_PATTERN = 3'd3,
        MODE_BLINK   = 3'd4,
        MODE_CHASE   = 3'd5,
        MODE_WIN     = 3'd6,
        MODE_FAULT   = 3'd7
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [LED_W-1:0]   pattern_q, pattern_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CHASE_W-1:0] chase_q, chase_d;
    logic [SUB_W-1:0]   sub_q, sub_d;
    logic               blink_ph_q, blink_ph_d;
    logic [FL_W-1:0]    flash_cnt_q, flash_cnt_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               flash_done_q, flash_done_d;
    logic               tick;
    logic [FL_W-1:0]    flash_next;
    logic [LED_W-1:0]   mode_val;
    logic [LED_W-1:0]   fault_pat;
`ifdef LED_DIM_EN
    logic [3:0]         pwm_q, pwm_d;
`endif

    // State register; reset aborts any animation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_OFF;
            pattern_q    <= '0;
            pre_q        <= '0;
            chase_q      <= '0;
            sub_q        <= '0;
            blink_ph_q   <= 1'b1;
            flash_cnt_q  <= '0;
            leds_q       <= '0;
            flash_done_q <= 1'b0;
`ifdef LED_DIM_EN
            pwm_q        <= '0;
`endif
        end else begin
            mode_q       <= mode_d;
            pattern_q    <= pattern_d;
            pre_q        <= pre_d;
            chase_q      <= chase_d;
            sub_q        <= sub_d;
            blink_ph_q   <= blink_ph_d;
            flash_cnt_q  <= flash_cnt_d;
            leds_q       <= leds_d;
            flash_done_q <= flash_done_d;
`ifdef LED_DIM_EN
            pwm_q        <= pwm_d;
`endif
        end
    end

    // Next-state: prescaler tick, mode load, per-mode animation, and the LED value for this mode.
    always_comb begin
        mode_d       = mode_q;
        pattern_d    = pattern_q;
        chase_d      = chase_q;
        sub_d        = sub_q;
        blink_ph_d   = blink_ph_q;
        flash_cnt_d  = flash_cnt_q;
        flash_done_d = 1'b0;
        fault_pat    = '0;
        mode_val     = '0;

        tick       = (pre_q == PRE_MAX);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        flash_next = flash_cnt_q + 1'b1;

        for (int i = 0; i < LED_W; i++) begin
            fault_pat[i] = (i % 2 == 0);
        end

        case (mode_q)
            MODE_OFF:     mode_val = '0;
            MODE_ON:      mode_val = '1;
            MODE_SCORE:   mode_val = score;
            MODE_PATTERN: mode_val = pattern_q;
            MODE_BLINK:   mode_val = blink_ph_q ? score : '0;
            MODE_CHASE:   mode_val = LED_W'(1) << chase_q;
            MODE_WIN:     mode_val = blink_ph_q ? '1 : '0;
            MODE_FAULT:   mode_val = fault_pat;
            default:      mode_val = '0;
        endcase

`ifdef LED_DIM_EN
        pwm_d  = pwm_q + 1'b1;
        leds_d = mode_val & {LED_W{(pwm_q < brightness)}};
`else
        leds_d = mode_val;
`endif

        if (mode_load) begin
            // A load restarts every animation counter and swallows a coincident tick.
            mode_d      = mode_e'(mode);
            pattern_d   = pattern;
            pre_d       = '0;
            chase_d     = '0;
            sub_d       = '0;
            flash_cnt_d = '0;
            blink_ph_d  = 1'b1;
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: begin
                    if (sub_q == SUB_MAX) begin
                        sub_d      = '0;
                        blink_ph_d = ~blink_ph_q;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
                MODE_CHASE: begin
                    chase_d = (chase_q == CHASE_MAX) ? '0 : chase_q + 1'b1;
                end
                MODE_WIN: begin
                    blink_ph_d = ~blink_ph_q;
                    // A flash is counted each time the LEDs come back on.
                    if (!blink_ph_q) begin
                        if (flash_next == FL_MAX) begin
                            mode_d       = MODE_SCORE;
                            flash_done_d = 1'b1;
                            flash_cnt_d  = '0;
                            blink_ph_d   = 1'b1;
                        end else begin
                            flash_cnt_d = flash_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign leds_out   = leds_q;
    assign flash_done = flash_done_q;

endmodule

// File: tb/tb_led_display_ctrl.sv
// tb/tb_led_display_ctrl.sv - randomized self-checking bench for led_display_ctrl against an elapsed-time model
module tb_led_display_ctrl;

    localparam int W  = 8;
    localparam int TD = 4;
    localparam int BT = 1;
    localparam int FC = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode_load = 1'b0;
    logic [2:0]   mode = 3'd0;
    logic [W-1:0] pattern = '0;
    logic [W-1:0] score = '0;
`ifdef LED_DIM_EN
    logic [3:0]   brightness = 4'd15;
`endif
    logic [W-1:0] leds_out;
    logic         flash_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Model: current mode, latched pattern, clock edges since the last load, edges since reset.
    int           m_mode;
    int           m_n;
    logic [W-1:0] m_pat;
    int           g_edges;

    led_display_ctrl #(
        .LED_W(W), .TICK_DIV(TD), .BLINK_TICKS(BT), .FLASH_CNT(FC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode_load(mode_load),
        .mode(mode),
        .pattern(pattern),
        .score(score),
`ifdef LED_DIM_EN
        .brightness(brightness),
`endif
        .leds_out(leds_out),
        .flash_done(flash_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // LED value of a mode after k animation ticks since it was loaded.
    function automatic logic [W-1:0] mval(input int m, input int k, input logic [W-1:0] sc,
                                           input logic [W-1:0] pat);
        logic [W-1:0] one;
        one = 1;
        case (m)
            0:       return '0;
            1:       return '1;
            2:       return sc;
            3:       return pat;
            4:       return ((k / BT) % 2 == 0) ? sc : '0;
            5:       return one << (k % W);
            6:       return (k % 2 == 0) ? '1 : '0;
            default: return 8'h55;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_n     = 0;
        m_pat   = '0;
        g_edges = 0;
    endtask

    // One clock: drive inputs, predict the registered outputs after the edge, compare.
    task automatic step(input logic ld, input int m, input logic [W-1:0] p, input logic [W-1:0] s);
        logic [W-1:0] e_leds;
        logic         e_done;
        @(negedge clk);
        mode_load = ld;
        mode      = 3'(m);
        pattern   = p;
        score     = s;
        e_leds = mval(m_mode, m_n / TD, s, m_pat);
`ifdef LED_DIM_EN
        if (!((g_edges % 16) < int'(brightness))) e_leds = '0;
`endif
        e_done = (m_mode == 6) && !ld && ((m_n + 1) == 2 * FC * TD);
        if (ld) begin
            m_mode = m;
            m_pat  = p;
            m_n    = 0;
        end else begin
            m_n++;
            if (e_done) m_mode = 2;
        end
        g_edges++;
        @(posedge clk);
        #1;
        chk("leds_out", 32'(leds_out), 32'(e_leds));
        chk("flash_done", 32'(flash_done), 32'(e_done));
    endtask

    task automatic run(input int n, input logic [W-1:0] s);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, s);
    endtask

    task automatic run_rand(input int n);
        logic [W-1:0] s;
        s = W'($urandom);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) s = W'($urandom);
            step(1'b0, $urandom_range(0, 7), W'($urandom), s);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_leds", 32'(leds_out), 32'h0);
        chk("reset_done", 32'(flash_done), 32'h0);
        rst_n = 1'b1;

        // Score pass-through with one-cycle latency.
        step(1'b1, 2, 8'h00, 8'h3C);
        step(1'b0, 0, 8'h00, 8'h3C);
        step(1'b0, 0, 8'h00, 8'h81);
        step(1'b0, 0, 8'h00, 8'h81);

        // Chase across a full wrap.
        step(1'b1, 5, 8'h00, 8'h00);
        run(40, 8'h00);

        // Asynchronous reset mid-chase.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_leds", 32'(leds_out), 32'h0);
        chk("async_rst_done", 32'(flash_done), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        run(3, 8'hA5);

        // Win flash to completion, then back to score.
        step(1'b1, 6, 8'h00, 8'h5A);
        run(30, 8'h5A);

        // Blink with a reload landing on the tick cycle.
        step(1'b1, 4, 8'h00, 8'hF0);
        run(3, 8'hF0);
        step(1'b1, 4, 8'h00, 8'hF0);
        run(12, 8'hF0);

        // Win aborted by a load: no completion pulse.
        step(1'b1, 6, 8'h00, 8'h11);
        run(10, 8'h11);
        step(1'b1, 3, 8'hC3, 8'h11);
        run(30, 8'h22);

        // Fault and static modes.
        step(1'b1, 7, 8'h00, 8'h00);
        run(3, 8'h00);
        step(1'b1, 1, 8'h00, 8'h00);
        run(3, 8'h00);

        // Randomized mode sequences of random length.
        for (int ph = 0; ph < 60; ph++) begin
`ifdef LED_DIM_EN
            brightness = 4'($urandom);
`endif
            step(1'b1, $urandom_range(0, 7), W'($urandom), W'($urandom));
            run_rand($urandom_range(1, 40));
        end

`ifdef LED_DIM_EN
        brightness = 4'd0;
        step(1'b1, 1, 8'h00, 8'h00);
        run(20, 8'h00);
        brightness = 4'd4;
        run(32, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
